// File: rtl/pipe_ctrl_param.sv
// Pipeline controller: merges per-stage stall requests, sequences exception flush/redirect and
// watches for runaway stalls. Optional per-request stall counters under STALL_PERF_CNT_EN.
module pipe_ctrl_param #(
    parameter int unsigned          N_STAGES      = 6,
    parameter int unsigned          N_REQ         = 2,
    parameter logic [4*N_REQ-1:0]   REQ_STAGE     = {4'd3, 4'd2},
    parameter int unsigned          FLUSH_CYCLES  = 1,
    parameter int unsigned          STALL_TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    stallreq,
    input  logic                flush_req,
    input  logic [31:0]         flush_pc,
    output logic [N_STAGES-1:0] stall,
    output logic [N_STAGES-1:0] flush,
    output logic                new_pc_valid,
    output logic [31:0]         new_pc,
    output logic                stall_timeout,
    input  logic [3:0]          perf_sel,
    output logic [31:0]         perf_cnt
);

    localparam int unsigned WdW = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e         state_q, state_d;
    logic [3:0]     flush_cnt_q, flush_cnt_d;
    logic [31:0]    new_pc_q, new_pc_d;
    logic           pulse_q, pulse_d;
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_q, timeout_d;

    logic                any_req;
    logic [3:0]          s_max;
    logic [N_STAGES-1:0] stall_mask;

    function automatic logic [3:0] clamp_stage(input logic [3:0] s);
        if (32'(s) >= N_STAGES) return 4'(N_STAGES - 1);
        return s;
    endfunction

    // Deepest requesting stage wins; everything upstream of it holds.
    always_comb begin
        any_req = 1'b0;
        s_max   = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (stallreq[j]) begin
                any_req = 1'b1;
                if (clamp_stage(REQ_STAGE[4*j +: 4]) >= s_max) begin
                    s_max = clamp_stage(REQ_STAGE[4*j +: 4]);
                end
            end
        end
        for (int unsigned k = 0; k < N_STAGES; k++) begin
            stall_mask[k] = any_req && (k <= 32'(s_max));
        end
    end

    always_comb begin
        stall        = '0;
        flush        = '0;
        new_pc_valid = 1'b0;
        if (rst) begin
            if (state_q == StFlush) begin
                flush        = '1;
                new_pc_valid = pulse_q;
            end else if (!flush_req) begin
                stall = stall_mask;
            end
        end
    end

    // A new flush request always restarts the sequence, in either state.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        new_pc_d    = new_pc_q;
        pulse_d     = 1'b0;
        if (flush_req) begin
            state_d     = StFlush;
            flush_cnt_d = 4'(FLUSH_CYCLES - 1);
            new_pc_d    = flush_pc;
            pulse_d     = 1'b1;
        end else if (state_q == StFlush) begin
            if (flush_cnt_q == '0) begin
                state_d = StRun;
            end else begin
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
        end
    end

    // stall is already zero in FLUSH and on a flush_req cycle, which clears the count.
    always_comb begin
        timeout_d = timeout_q | (wd_cnt_q == WdW'(STALL_TIMEOUT));
        if (|stall) begin
            wd_cnt_d = (wd_cnt_q == WdW'(STALL_TIMEOUT)) ? wd_cnt_q : wd_cnt_q + WdW'(1);
        end else begin
            wd_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            new_pc_q    <= '0;
            pulse_q     <= 1'b0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            new_pc_q    <= new_pc_d;
            pulse_q     <= pulse_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign new_pc        = new_pc_q;
    assign stall_timeout = timeout_q;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_q [N_REQ];
    logic [31:0] perf_d [N_REQ];

    always_comb begin
        for (int unsigned j = 0; j < N_REQ; j++) begin
            perf_d[j] = perf_q[j] + 32'((state_q == StRun) && stallreq[j]);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!rst) begin
                perf_q[j] <= '0;
            end else begin
                perf_q[j] <= perf_d[j];
            end
        end
    end

    always_comb begin
        perf_cnt = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (perf_sel == 4'(j)) perf_cnt = perf_q[j];
        end
    end
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel;
    assign perf_cnt        = '0;
`endif

endmodule
